// File: rtl/bram_vec_pkg.sv
// Shared definitions for the BRAM vector engine: operation codes and FSM encoding.
package bram_vec_pkg;

    localparam logic [1:0] MODE_ADD  = 2'd0;
    localparam logic [1:0] MODE_SUB  = 2'd1;
    localparam logic [1:0] MODE_SADD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } state_t;

endpackage

// File: rtl/bram_vec_alu_if.sv
// Control handshake plus the A/B read port and C write port of the vector engine.
interface bram_vec_alu_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
);
    logic                  start;
    logic [ADDR_W:0]       len;
    logic [1:0]            mode;
    logic                  busy;
    logic                  done;
    logic                  ovf;
    logic                  en_ab;
    logic [ADDR_W-1:0]     addr_ab;
    logic [DATA_W-1:0]     dout_a;
    logic [DATA_W-1:0]     dout_b;
    logic                  en_c;
    logic [ADDR_W-1:0]     addr_c;
    logic [DATA_W-1:0]     din_c;
    logic [DATA_W/8-1:0]   web_c;

    modport master (
        input  start, len, mode, dout_a, dout_b,
        output busy, done, ovf, en_ab, addr_ab, en_c, addr_c, din_c, web_c
    );

    modport slave (
        output start, len, mode, dout_a, dout_b,
        input  busy, done, ovf, en_ab, addr_ab, en_c, addr_c, din_c, web_c
    );
endinterface

// File: rtl/bram_vec_alu_alu.sv
// Per-element arithmetic: modular add/sub with carry/borrow, and signed
// saturating add. The reserved mode code falls back to plain add.
module vec_alu
    import bram_vec_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [1:0]        mode,
    output logic [DATA_W-1:0] result,
    output logic              ovf_elem
);
    localparam logic [DATA_W-1:0] SMAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SMIN = {1'b1, {(DATA_W-1){1'b0}}};

    logic [DATA_W:0] sum_s;
    logic [DATA_W:0] diff_s;
    logic            sovf_s;

    assign sum_s  = {1'b0, a} + {1'b0, b};
    assign diff_s = {1'b0, a} - {1'b0, b};
    // Signed overflow: operands agree in sign but the sum does not.
    assign sovf_s = (a[DATA_W-1] == b[DATA_W-1]) && (sum_s[DATA_W-1] != a[DATA_W-1]);

    // Operation select
    always_comb begin
        result   = sum_s[DATA_W-1:0];
        ovf_elem = sum_s[DATA_W];
        case (mode)
            MODE_ADD: begin
                result   = sum_s[DATA_W-1:0];
                ovf_elem = sum_s[DATA_W];
            end
            MODE_SUB: begin
                result   = diff_s[DATA_W-1:0];
                ovf_elem = diff_s[DATA_W];
            end
            MODE_SADD: begin
                ovf_elem = sovf_s;
                if (sovf_s) begin
                    result = a[DATA_W-1] ? SMIN : SMAX;
                end else begin
                    result = sum_s[DATA_W-1:0];
                end
            end
            default: begin
                result   = sum_s[DATA_W-1:0];
                ovf_elem = sum_s[DATA_W];
            end
        endcase
    end

endmodule

// File: rtl/bram_vec_alu.sv
// Streaming vector engine: reads len A/B word pairs from address 0 upward,
// combines them in vec_alu and writes each result to C at the same address.
module bram_vec_alu
    import bram_vec_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter int RD_LAT = 1
) (
    input  logic           clk,
    input  logic           reset,
    bram_vec_alu_if.master bus
);
    localparam int              WB_W    = DATA_W / 8;
    localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_t              state_r;
    state_t              state_nxt_s;
    logic [ADDR_W:0]     len_r;
    logic [ADDR_W:0]     cnt_r;
    logic [1:0]          mode_r;
    logic                en_ab_r;
    logic [ADDR_W-1:0]   addr_ab_r;
    logic [RD_LAT-1:0]   vld_r;
    logic [ADDR_W-1:0]   addr_dly_r [RD_LAT];
    logic                en_c_r;
    logic [ADDR_W-1:0]   addr_c_r;
    logic [DATA_W-1:0]   din_c_r;
    logic [WB_W-1:0]     web_c_r;
    logic                busy_r;
    logic                done_r;
    logic                ovf_r;
    logic                accept_s;
    logic                issue_s;
    logic                last_issue_s;
    logic                busy_s;
    logic                fin_s;
    logic                pend_s;
    logic                wr_vld_s;
    logic [DATA_W-1:0]   alu_res_s;
    logic                alu_ovf_s;

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (bus.len == {(ADDR_W+1){1'b0}}) begin
                        state_nxt_s = ST_FIN;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_issue_s) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (pend_s) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_FIN;
                end
            end
            ST_FIN:  state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM output decode; DRAIN may end while the data stage still holds the
    // last element, because its write lands on the same edge as entering FIN.
    always_comb begin
        accept_s     = 1'b0;
        issue_s      = 1'b0;
        last_issue_s = 1'b0;
        busy_s       = 1'b0;
        fin_s        = 1'b0;
        case (state_r)
            ST_IDLE:  accept_s = bus.start;
            ST_RUN: begin
                issue_s      = 1'b1;
                busy_s       = 1'b1;
                last_issue_s = (cnt_r == (len_r - CNT_ONE));
            end
            ST_DRAIN: busy_s = 1'b1;
            ST_FIN: begin
                busy_s = 1'b1;
                fin_s  = 1'b1;
            end
            default: busy_s = 1'b0;
        endcase
        pend_s = en_ab_r;
        for (int j = 0; j < RD_LAT - 1; j++) begin
            pend_s = pend_s | vld_r[j];
        end
    end

    assign wr_vld_s = vld_r[RD_LAT-1];

    vec_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .a        (bus.dout_a),
        .b        (bus.dout_b),
        .mode     (mode_r),
        .result   (alu_res_s),
        .ovf_elem (alu_ovf_s)
    );

    // Run control: latched operands, element counter, status flags
    always_ff @(posedge clk) begin
        if (reset) begin
            len_r  <= {(ADDR_W+1){1'b0}};
            mode_r <= 2'd0;
            cnt_r  <= {(ADDR_W+1){1'b0}};
            busy_r <= 1'b0;
            done_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            busy_r <= busy_s;
            done_r <= fin_s;
            if (accept_s) begin
                len_r  <= bus.len;
                mode_r <= bus.mode;
                cnt_r  <= {(ADDR_W+1){1'b0}};
            end else if (issue_s) begin
                cnt_r <= cnt_r + CNT_ONE;
            end
            if (accept_s) begin
                ovf_r <= 1'b0;
            end else if (wr_vld_s && alu_ovf_s) begin
                ovf_r <= 1'b1;
            end
        end
    end

    // Read issue and the valid/address delay line matching BRAM latency
    always_ff @(posedge clk) begin
        if (reset) begin
            en_ab_r   <= 1'b0;
            addr_ab_r <= {ADDR_W{1'b0}};
            vld_r     <= {RD_LAT{1'b0}};
            for (int j = 0; j < RD_LAT; j++) begin
                addr_dly_r[j] <= {ADDR_W{1'b0}};
            end
        end else begin
            en_ab_r <= issue_s;
            if (issue_s) begin
                addr_ab_r <= cnt_r[ADDR_W-1:0];
            end
            vld_r[0]      <= en_ab_r;
            addr_dly_r[0] <= addr_ab_r;
            for (int j = 1; j < RD_LAT; j++) begin
                vld_r[j]      <= vld_r[j-1];
                addr_dly_r[j] <= addr_dly_r[j-1];
            end
        end
    end

    // Write port registers; address and data hold between writes
    always_ff @(posedge clk) begin
        if (reset) begin
            en_c_r   <= 1'b0;
            addr_c_r <= {ADDR_W{1'b0}};
            din_c_r  <= {DATA_W{1'b0}};
            web_c_r  <= {WB_W{1'b0}};
        end else begin
            en_c_r  <= wr_vld_s;
            web_c_r <= wr_vld_s ? {WB_W{1'b1}} : {WB_W{1'b0}};
            if (wr_vld_s) begin
                addr_c_r <= addr_dly_r[RD_LAT-1];
                din_c_r  <= alu_res_s;
            end
        end
    end

    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.ovf     = ovf_r;
    assign bus.en_ab   = en_ab_r;
    assign bus.addr_ab = addr_ab_r;
    assign bus.en_c    = en_c_r;
    assign bus.addr_c  = addr_c_r;
    assign bus.din_c   = din_c_r;
    assign bus.web_c   = web_c_r;

endmodule

// File: tb/tb_bram_vec_alu.sv
// Directed bench for bram_vec_alu: one engine with 1-cycle BRAMs and one with
// 3-cycle BRAMs, negedge monitors collecting writes, reads and done pulses.
module tb_bram_vec_alu;
    import bram_vec_pkg::*;

    localparam int DW = 32;
    localparam int AW = 10;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic clr   = 1'b0;
    int   cyc   = 0;
    int   t0    = 0;
    int   checks = 0;
    int   errors = 0;

    logic [DW-1:0] amem  [0:1023];
    logic [DW-1:0] bmem  [0:1023];
    logic [DW-1:0] cmem0 [0:1023];
    logic [DW-1:0] cmem1 [0:1023];
    logic [DW-1:0] pa1 [3];
    logic [DW-1:0] pb1 [3];

    int wr0 = 0, rd0 = 0, dn0 = 0, dcyc0 = 0, webbad0 = 0, webstray0 = 0;
    int wr1 = 0, dn1 = 0, dcyc1 = 0, first1 = -1, last1 = 0, addrbad1 = 0;

    bram_vec_alu_if #(.DATA_W(DW), .ADDR_W(AW)) bus0 ();
    bram_vec_alu_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();

    bram_vec_alu #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(1)) u0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    bram_vec_alu #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(3)) u1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // single-cycle BRAM pair for u0
    always @(posedge clk) begin
        if (bus0.en_ab) begin
            bus0.dout_a <= amem[bus0.addr_ab];
            bus0.dout_b <= bmem[bus0.addr_ab];
        end
    end

    // three-cycle BRAM pair for u1
    always @(posedge clk) begin
        if (bus1.en_ab) begin
            pa1[0] <= amem[bus1.addr_ab];
            pb1[0] <= bmem[bus1.addr_ab];
        end
        pa1[1] <= pa1[0];
        pb1[1] <= pb1[0];
        pa1[2] <= pa1[1];
        pb1[2] <= pb1[1];
    end
    assign bus1.dout_a = pa1[2];
    assign bus1.dout_b = pb1[2];

    always @(negedge clk) begin
        if (clr) begin
            wr0 <= 0; rd0 <= 0; dn0 <= 0; webbad0 <= 0; webstray0 <= 0;
        end else begin
            if (bus0.en_ab) rd0 <= rd0 + 1;
            if (bus0.en_c) begin
                cmem0[bus0.addr_c] <= bus0.din_c;
                wr0 <= wr0 + 1;
                if (bus0.web_c != 4'hF) webbad0 <= webbad0 + 1;
            end else if (bus0.web_c != 4'h0) begin
                webstray0 <= webstray0 + 1;
            end
            if (bus0.done) begin
                dn0   <= dn0 + 1;
                dcyc0 <= cyc;
            end
        end
    end

    always @(negedge clk) begin
        if (clr) begin
            wr1 <= 0; dn1 <= 0; first1 <= -1; addrbad1 <= 0;
        end else begin
            if (bus1.en_c) begin
                cmem1[bus1.addr_c] <= bus1.din_c;
                wr1   <= wr1 + 1;
                last1 <= cyc;
                if (first1 < 0) first1 <= cyc;
                if (int'(bus1.addr_c) != wr1) addrbad1 <= addrbad1 + 1;
            end
            if (bus1.done) begin
                dn1   <= dn1 + 1;
                dcyc1 <= cyc;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // clears the monitors, then presents start for one edge (edge 0 of the run)
    task automatic go(input int inst, input int n, input logic [1:0] m);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        if (inst == 0) begin
            bus0.start = 1'b1; bus0.len = 11'(n); bus0.mode = m;
        end else begin
            bus1.start = 1'b1; bus1.len = 11'(n); bus1.mode = m;
        end
        tick(1);
        t0 = cyc;
        bus0.start = 1'b0;
        bus1.start = 1'b0;
    endtask

    task automatic wait_done(input int inst, input int budget);
        for (int i = 0; i < budget; i++) begin
            if ((inst == 0 ? dn0 : dn1) != 0) break;
            tick(1);
        end
        chk("done_count", (inst == 0) ? dn0 : dn1, 1);
    endtask

    initial begin
        bus0.start = 1'b0; bus0.len = 11'd0; bus0.mode = 2'd0;
        bus1.start = 1'b0; bus1.len = 11'd0; bus1.mode = 2'd0;
        tick(3);
        chk("rst_ctl0", {bus0.busy, bus0.done, bus0.ovf, bus0.en_ab, bus0.en_c, bus0.web_c}, 64'h0);
        chk("rst_dat0", {bus0.addr_ab, bus0.addr_c, bus0.din_c}, 64'h0);
        chk("rst_ctl1", {bus1.busy, bus1.done, bus1.ovf, bus1.en_ab, bus1.en_c, bus1.web_c}, 64'h0);
        reset = 1'b0;
        tick(1);

        // basic add, len=4
        for (int i = 0; i < 4; i++) begin
            amem[i] = 32'(i + 1);
            bmem[i] = 32'(10 * (i + 1));
        end
        go(0, 4, MODE_ADD);
        wait_done(0, 40);
        for (int i = 0; i < 4; i++) chk("add_c", cmem0[i], 64'(11 * (i + 1)));
        chk("add_done_cyc", dcyc0 - t0, 7);
        chk("add_ovf", bus0.ovf, 0);
        chk("add_writes", wr0, 4);
        chk("add_reads", rd0, 4);
        chk("add_web", webbad0, 0);
        chk("add_web_idle", webstray0, 0);
        chk("add_busy_end", bus0.busy, 0);

        // add carry-out
        amem[0] = 32'hFFFF_FFFF; bmem[0] = 32'h2;
        go(0, 1, MODE_ADD);
        wait_done(0, 40);
        chk("addc_c", cmem0[0], 64'h1);
        chk("addc_ovf", bus0.ovf, 1);
        chk("addc_done_cyc", dcyc0 - t0, 4);

        // sub borrow
        amem[0] = 32'h3; bmem[0] = 32'h5;
        go(0, 1, MODE_SUB);
        wait_done(0, 40);
        chk("sub_c", cmem0[0], 64'hFFFF_FFFE);
        chk("sub_ovf", bus0.ovf, 1);

        // signed saturating add: clamp high, clamp low, in range
        amem[0] = 32'h7FFF_FFF0; bmem[0] = 32'h0000_0020;
        amem[1] = 32'h8000_0000; bmem[1] = 32'hFFFF_FFFF;
        amem[2] = 32'hFFFF_FFFE; bmem[2] = 32'h0000_0005;
        go(0, 3, MODE_SADD);
        wait_done(0, 40);
        chk("sadd_max", cmem0[0], 64'h7FFF_FFFF);
        chk("sadd_min", cmem0[1], 64'h8000_0000);
        chk("sadd_mid", cmem0[2], 64'h3);
        chk("sadd_ovf", bus0.ovf, 1);

        // reserved mode acts as add; new start clears the sticky flag
        amem[0] = 32'h5; bmem[0] = 32'h6;
        go(0, 1, 2'd3);
        wait_done(0, 40);
        chk("rsv_c", cmem0[0], 64'hB);
        chk("rsv_ovf", bus0.ovf, 0);

        // zero length
        go(0, 0, MODE_ADD);
        wait_done(0, 10);
        chk("len0_done_cyc", dcyc0 - t0, 1);
        chk("len0_reads", rd0, 0);
        chk("len0_writes", wr0, 0);
        chk("len0_web", webstray0, 0);

        // read latency 3
        for (int i = 0; i < 5; i++) begin
            amem[i] = 32'(100 + i);
            bmem[i] = 32'(2 * i);
        end
        go(1, 5, MODE_ADD);
        wait_done(1, 40);
        chk("lat3_first_wr", first1 - t0, 5);
        chk("lat3_last_wr", last1 - t0, 9);
        chk("lat3_writes", wr1, 5);
        chk("lat3_addr_order", addrbad1, 0);
        chk("lat3_done_cyc", dcyc1 - t0, 10);
        for (int i = 0; i < 5; i++) chk("lat3_c", cmem1[i], 64'(100 + 3 * i));

        // start pulsed while running is ignored
        amem[0] = 32'd1; amem[1] = 32'd2; amem[2] = 32'hFFFF_FFFF; amem[3] = 32'd4;
        bmem[0] = 32'd10; bmem[1] = 32'd20; bmem[2] = 32'd1; bmem[3] = 32'd40;
        go(0, 4, MODE_ADD);
        tick(2);
        bus0.start = 1'b1; bus0.len = 11'd2; bus0.mode = MODE_SUB;
        tick(1);
        bus0.start = 1'b0;
        wait_done(0, 40);
        tick(10);
        chk("busy_start_dones", dn0, 1);
        chk("busy_start_writes", wr0, 4);
        chk("busy_start_done_cyc", dcyc0 - t0, 7);
        chk("busy_start_c2", cmem0[2], 64'h0);
        chk("busy_start_c3", cmem0[3], 64'd44);
        chk("busy_start_ovf", bus0.ovf, 1);

        amem[0] = 32'd1; bmem[0] = 32'd10;
        go(0, 1, MODE_ADD);
        chk("restart_ovf_clr", bus0.ovf, 0);
        wait_done(0, 40);
        chk("restart_c", cmem0[0], 64'd11);

        // reset in cycle 3 of a len=8 run
        for (int i = 0; i < 8; i++) begin
            amem[i] = 32'(i);
            bmem[i] = 32'(i);
        end
        go(0, 8, MODE_ADD);
        tick(3);
        reset = 1'b1;
        tick(1);
        chk("midrst_ctl", {bus0.busy, bus0.done, bus0.ovf, bus0.en_ab, bus0.en_c, bus0.web_c}, 64'h0);
        chk("midrst_dat", {bus0.addr_ab, bus0.addr_c, bus0.din_c}, 64'h0);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        reset = 1'b0;
        tick(20);
        chk("midrst_writes", wr0, 0);
        chk("midrst_reads", rd0, 0);
        chk("midrst_dones", dn0, 0);

        amem[0] = 32'd7; amem[1] = 32'd8; bmem[0] = 32'd1; bmem[1] = 32'd1;
        go(0, 2, MODE_ADD);
        wait_done(0, 40);
        chk("post_rst_c0", cmem0[0], 64'd8);
        chk("post_rst_c1", cmem0[1], 64'd9);
        chk("post_rst_done_cyc", dcyc0 - t0, 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
